// File: rtl/muldiv_if.sv
// EX-stage handshake between the pipeline and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one-bit-per-cycle shift-add multiplier
// and restoring divider on operand magnitudes, stalling EX until the result is ready.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int               CW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         fn;
    logic               sign_a, sign_b;
    logic [2*WIDTH-1:0] acc;      // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   result;

    logic               in_div, in_sa, in_sb, div_zero, div_ovf, in_special;
    logic [WIDTH-1:0]   mag_a, mag_b, special_res;

    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_nx, div_nx, step_nx, prod;
    logic [WIDTH-1:0]   quot, rem, calc_res;

    // Decode signedness and the divide special cases straight from the EX operands.
    always_comb begin
        in_div      = bus.funct3[2];
        in_sa       = (in_div ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11)) && bus.op_a[WIDTH-1];
        in_sb       = (in_div ? !bus.funct3[0] : !bus.funct3[1]) && bus.op_b[WIDTH-1];
        mag_a       = in_sa ? -bus.op_a : bus.op_a;
        mag_b       = in_sb ? -bus.op_b : bus.op_b;
        div_zero    = in_div && (bus.op_b == '0);
        div_ovf     = in_div && !bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
        in_special  = div_zero || div_ovf;
        special_res = div_zero ? (bus.funct3[1] ? bus.op_a : ALL_ONES)
                               : (bus.funct3[1] ? '0 : bus.op_a);
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nx    = {mul_sum, acc[WIDTH-1:1]};
        // Borrow out of the trial subtraction means the divisor did not fit: restore.
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        div_nx    = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        step_nx   = fn[2] ? div_nx : mul_nx;
        prod      = (sign_a ^ sign_b) ? -mul_nx : mul_nx;
        quot      = (sign_a ^ sign_b) ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
        rem       = sign_a ? -div_nx[2*WIDTH-1:WIDTH] : div_nx[2*WIDTH-1:WIDTH];
        case (fn)
            3'b000:                calc_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:        calc_res = quot;
            default:               calc_res = rem;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start && !bus.flush) state_nx = in_special ? DONE : CALC;
            CALC:    if (bus.flush)               state_nx = IDLE;
                     else if (cnt == '0)          state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fn     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.flush) begin
                    fn     <= bus.funct3;
                    sign_a <= in_sa;
                    sign_b <= in_sb;
                    cnt    <= CW'(WIDTH-1);
                    acc    <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                    opnd   <= in_div ? mag_b : mag_a;
                    if (in_special) result <= special_res;
                end
                CALC: if (!bus.flush) begin
                    acc <= step_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) result <= calc_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result;
    assign bus.done   = (state == DONE);
    assign bus.stall  = !rst && !bus.flush && ((state == IDLE && bus.start) || state == CALC);
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, flush/reset sequences,
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus();
    muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp = '0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        int          ia = $signed(a);
        int          ib = $signed(b);
        logic [63:0] p;
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(b)); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return W + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the done cycle with start still high,
    // so a following call presents the next instruction right after DONE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat,
                          output bit stall_ok, output bit pulse_ok);
        int c;
        stall_ok = 1'b1;
        pulse_ok = 1'b1;
        lat      = -1;
        res      = 'x;
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.flush = 1'b0;
        #1;
        if (bus.stall !== 1'b1) stall_ok = 1'b0;
        c = 0;
        while (c < 60) begin
            @(posedge clk); @(negedge clk);
            c++;
            if (bus.done === 1'b1) begin
                lat = c;
                res = bus.result;
                if (bus.stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        if (bus.done !== 1'b0) pulse_ok = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          s_ok, p_ok;
        run_op(f, a, b, res, lat, s_ok, p_ok);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " stall"}, 32'(s_ok), 32'd1);
        check({name, " single pulse"}, 32'(p_ok), 32'd1);
        last_exp = exp;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33};
        vecs[5]  = '{3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33};
        vecs[6]  = '{3'd5, 32'd20,       32'd3,        32'd6,        33};
        vecs[7]  = '{3'd7, 32'd20,       32'd3,        32'd2,        33};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[13] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
        vecs[14] = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[15] = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[16] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33};

        rst = 1'b1;
        bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
        #3;
        check("reset stall", 32'(bus.stall), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // flush in IDLE together with start: not accepted
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd9; bus.op_b = 32'd2; bus.flush = 1'b1;
        #1 check("idle flush stall", 32'(bus.stall), 32'd0);
        @(posedge clk); @(negedge clk);
        bus.flush = 1'b0; bus.start = 1'b0;
        #1 check("idle flush not accepted", 32'(bus.stall), 32'd0);
        check("idle flush no done", 32'(bus.done), 32'd0);
        @(negedge clk);

        // flush in cycle 10 of CALC, then an immediate new start
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd1234; bus.op_b = 32'd5678;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        check("pre-flush done", 32'(bus.done), 32'd0);
        bus.flush = 1'b1;
        #1 check("flush stall low", 32'(bus.stall), 32'd0);
        @(posedge clk); @(negedge clk);
        bus.flush = 1'b0;
        check("post-flush done", 32'(bus.done), 32'd0);
        check("post-flush result held", bus.result, last_exp);
        do_op("after flush DIVU", 3'd5, 32'd1000, 32'd7, 32'd142, 33);

        // async reset in the middle of CALC
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4;
        repeat (15) begin @(posedge clk); @(negedge clk); end
        #2 rst = 1'b1;
        #1;
        check("mid-calc rst stall", 32'(bus.stall), 32'd0);
        check("mid-calc rst done", 32'(bus.done), 32'd0);
        check("mid-calc rst result", bus.result, 32'd0);
        @(negedge clk);
        check("held rst done", 32'(bus.done), 32'd0);
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        do_op("b2b MUL", 3'd0, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFF4, 33);
        do_op("b2b DIVU", 3'd5, 32'd100, 32'd9, 32'd11, 33);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            do_op($sformatf("rand%0d f=%0d a=%08h b=%08h", i, f, a, b), f, a, b,
                  ref_model(f, a, b), ref_latency(f, a, b));
        end

        bus.start = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
